// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StReq,
        StHold,
        StSusp
    } fetch_state_t;

    localparam logic [31:0] DefResetVector = 32'h0000_0000;
    localparam logic [31:0] DefNopInstr    = 32'hE1A0_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_fd_pipe_reg.sv
// F/D pipeline register: instruction, PC+8 and valid flag handed to decode.
module fd_pipe_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DefNopInstr,
    parameter logic [31:0] RESET_PC8 = DefResetVector + 32'd8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic        i_ld,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus8,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_plus8_d,
    output logic        o_valid_d
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus8;
    logic        r_valid;

    // Stall (i_en low) wins over clear; with nothing to load the register holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus8 <= RESET_PC8;
            r_valid    <= 1'b0;
        end else if (i_en) begin
            if (i_clr || i_bubble) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (i_ld) begin
                r_instr    <= i_instr;
                r_pc_plus8 <= i_pc_plus8;
                r_valid    <= 1'b1;
            end
        end
    end

    assign o_instr_d    = r_instr;
    assign o_pc_plus8_d = r_pc_plus8;
    assign o_valid_d    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, talks to a variable-latency instruction
// memory and applies E/W-stage redirects before handing off to the F/D register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DefResetVector,
    parameter logic [31:0] NOP_INSTR    = DefNopInstr
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_pc_wr_pending_f,
    input  logic        i_branch_taken_e,
    input  logic [31:0] i_branch_target_e,
    input  logic        i_pc_src_w,
    input  logic [31:0] i_result_w,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_plus8_d,
    output logic        o_valid_d,
    output logic        o_fetch_busy_f
);

    fetch_state_t r_state, w_state_d;
    logic [31:0]  r_pcf, w_pcf_d;
    logic         r_redir, w_redir_d;
    logic [31:0]  r_redir_tgt, w_redir_tgt_d;
    logic [31:0]  r_hold_instr, w_hold_instr_d;
    logic         r_outst;

    logic         w_redir;
    logic [31:0]  w_redir_tgt;
    logic         w_imem_req;
    logic         w_busy;
    logic         w_accept;
    logic [31:0]  w_pc_plus4;
    logic         w_fd_ld;
    logic         w_fd_bubble;
    logic [31:0]  w_fd_instr;

    assign w_redir     = i_pc_src_w | i_branch_taken_e;
    assign w_redir_tgt = word_align(i_pc_src_w ? i_result_w : i_branch_target_e);
    assign w_pc_plus4  = r_pcf + 32'd4;

    // A pending PC write only suppresses a fresh request; one already on the bus stays up.
    assign w_imem_req = i_rst_n & (r_state == StReq) & (~i_pc_wr_pending_f | r_outst);
    assign w_busy     = (r_state == StReq) & w_imem_req & ~i_imem_ready;
    assign w_accept   = w_imem_req & i_imem_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StReq;
            r_pcf        <= RESET_VECTOR;
            r_redir      <= 1'b0;
            r_redir_tgt  <= RESET_VECTOR;
            r_hold_instr <= NOP_INSTR;
            r_outst      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pcf        <= w_pcf_d;
            r_redir      <= w_redir_d;
            r_redir_tgt  <= w_redir_tgt_d;
            r_hold_instr <= w_hold_instr_d;
            r_outst      <= w_busy;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_pcf_d        = r_pcf;
        w_redir_d      = r_redir;
        w_redir_tgt_d  = r_redir_tgt;
        w_hold_instr_d = r_hold_instr;
        w_fd_ld        = 1'b0;
        w_fd_bubble    = 1'b0;
        w_fd_instr     = i_imem_rdata;

        if (w_redir) begin
            // ImemAddr must not move under a waiting request: park the target instead.
            if (w_busy) begin
                w_redir_d     = 1'b1;
                w_redir_tgt_d = w_redir_tgt;
            end else begin
                w_pcf_d   = w_redir_tgt;
                w_redir_d = 1'b0;
                w_state_d = StReq;
            end
        end else begin
            unique case (r_state)
                StReq: begin
                    if (w_accept) begin
                        if (r_redir) begin
                            w_pcf_d   = r_redir_tgt;
                            w_redir_d = 1'b0;
                        end else if (!i_stall_d && !i_stall_f) begin
                            w_fd_ld = 1'b1;
                            w_pcf_d = w_pc_plus4;
                        end else begin
                            w_hold_instr_d = i_imem_rdata;
                            w_state_d      = StHold;
                        end
                    end else if (!w_imem_req) begin
                        w_fd_bubble = 1'b1;
                        if (!i_stall_f) begin
                            w_state_d = StSusp;
                        end
                    end
                end
                StHold: begin
                    if (!i_stall_d && !i_stall_f) begin
                        w_fd_ld    = 1'b1;
                        w_fd_instr = r_hold_instr;
                        w_pcf_d    = w_pc_plus4;
                        w_state_d  = i_pc_wr_pending_f ? StSusp : StReq;
                    end
                end
                StSusp: begin
                    w_fd_bubble = 1'b1;
                    if (!i_pc_wr_pending_f && !i_stall_f) begin
                        w_state_d = StReq;
                    end
                end
                default: w_state_d = StReq;
            endcase
        end
    end

    fd_pipe_reg #(
        .NOP_INSTR (NOP_INSTR),
        .RESET_PC8 (RESET_VECTOR + 32'd8)
    ) u_fd_pipe_reg (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (~i_stall_d),
        .i_clr        (i_flush_d | w_redir),
        .i_ld         (w_fd_ld),
        .i_bubble     (w_fd_bubble),
        .i_instr      (w_fd_instr),
        .i_pc_plus8   (r_pcf + 32'd8),
        .o_instr_d    (o_instr_d),
        .o_pc_plus8_d (o_pc_plus8_d),
        .o_valid_d    (o_valid_d)
    );

    assign o_imem_req     = w_imem_req;
    assign o_imem_addr    = r_pcf;
    assign o_fetch_busy_f = w_busy;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns 0xE000_0000 | address.
module tb_fetch_stage;

    localparam logic [31:0] Nop = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f, stall_d, flush_d, pcwr;
    logic        br, pcsrc;
    logic [31:0] br_tgt, result_w;
    logic        req, rdy, busy, valid_d;
    logic [31:0] addr, rdata, instr_d, pc8_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rdata = 32'hE000_0000 | addr;

    fetch_stage dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_stall_f         (stall_f),
        .i_stall_d         (stall_d),
        .i_flush_d         (flush_d),
        .i_pc_wr_pending_f (pcwr),
        .i_branch_taken_e  (br),
        .i_branch_target_e (br_tgt),
        .i_pc_src_w        (pcsrc),
        .i_result_w        (result_w),
        .o_imem_req        (req),
        .o_imem_addr       (addr),
        .i_imem_ready      (rdy),
        .i_imem_rdata      (rdata),
        .o_instr_d         (instr_d),
        .o_pc_plus8_d      (pc8_d),
        .o_valid_d         (valid_d),
        .o_fetch_busy_f    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pcwr = 1'b0;
        br = 1'b0; pcsrc = 1'b0; br_tgt = '0; result_w = '0; rdy = 1'b1;
        tick(); tick(); #1;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_instr", instr_d, Nop);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_pc8", pc8_d, 32'h8);

        // Zero-wait streaming
        rst_n = 1'b1; #1;
        chk("rel_req", {31'd0, req}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        tick(); #1;
        chk("zw1_addr", addr, 32'h4);
        chk("zw1_instr", instr_d, 32'hE000_0000);
        chk("zw1_pc8", pc8_d, 32'h8);
        chk("zw1_valid", {31'd0, valid_d}, 32'd1);
        tick(); #1;
        chk("zw2_addr", addr, 32'h8);
        chk("zw2_instr", instr_d, 32'hE000_0004);
        chk("zw2_pc8", pc8_d, 32'hC);
        tick(); #1;
        chk("zw3_addr", addr, 32'hC);
        chk("zw3_pc8", pc8_d, 32'h10);

        // Ready delayed 3 cycles at 0x10
        tick(); rdy = 1'b0; #1;
        chk("w1_addr", addr, 32'h10);
        chk("w1_busy", {31'd0, busy}, 32'd1);
        chk("w1_instr", instr_d, 32'hE000_000C);
        tick(); #1;
        chk("w2_addr", addr, 32'h10);
        chk("w2_busy", {31'd0, busy}, 32'd1);
        chk("w2_instr", instr_d, 32'hE000_000C);
        tick(); #1;
        chk("w3_busy", {31'd0, busy}, 32'd1);
        tick(); rdy = 1'b1; #1;
        chk("w4_busy", {31'd0, busy}, 32'd0);
        chk("w4_addr", addr, 32'h10);
        chk("w4_instr", instr_d, 32'hE000_000C);
        tick(); #1;
        chk("w5_instr", instr_d, 32'hE000_0010);
        chk("w5_pc8", pc8_d, 32'h18);
        chk("w5_addr", addr, 32'h14);

        // StallD for two cycles while Ready
        tick(); stall_d = 1'b1; #1;
        chk("s1_instr", instr_d, 32'hE000_0014);
        chk("s1_addr", addr, 32'h18);
        tick(); #1;
        chk("s2_req", {31'd0, req}, 32'd0);
        chk("s2_instr", instr_d, 32'hE000_0014);
        tick(); stall_d = 1'b0; #1;
        chk("s3_req", {31'd0, req}, 32'd0);
        chk("s3_addr", addr, 32'h18);
        tick(); #1;
        chk("s4_instr", instr_d, 32'hE000_0018);
        chk("s4_pc8", pc8_d, 32'h20);
        chk("s4_addr", addr, 32'h1C);
        chk("s4_req", {31'd0, req}, 32'd1);
        tick(); #1;
        chk("s5_instr", instr_d, 32'hE000_001C);

        // Branch while a request is waiting
        tick(); rdy = 1'b0; br = 1'b1; br_tgt = 32'h0000_0102; #1;
        chk("b1_addr", addr, 32'h24);
        chk("b1_instr", instr_d, 32'hE000_0020);
        tick(); br = 1'b0; #1;
        chk("b2_valid", {31'd0, valid_d}, 32'd0);
        chk("b2_instr", instr_d, Nop);
        chk("b2_addr", addr, 32'h24);
        chk("b2_busy", {31'd0, busy}, 32'd1);
        tick(); rdy = 1'b1; #1;
        chk("b3_addr", addr, 32'h24);
        tick(); #1;
        chk("b4_addr", addr, 32'h100);
        chk("b4_valid", {31'd0, valid_d}, 32'd0);
        tick(); #1;
        chk("b5_instr", instr_d, 32'hE000_0100);
        chk("b5_pc8", pc8_d, 32'h108);

        // PCSrcW beats BranchTakenE
        tick(); pcsrc = 1'b1; result_w = 32'h200; br = 1'b1; br_tgt = 32'h300; #1;
        chk("p1_addr", addr, 32'h108);
        tick(); pcsrc = 1'b0; br = 1'b0; #1;
        chk("p2_addr", addr, 32'h200);
        chk("p2_valid", {31'd0, valid_d}, 32'd0);

        // PC write pending for 3 cycles, then a reset pulse
        tick(); pcwr = 1'b1; #1;
        chk("q1_req", {31'd0, req}, 32'd0);
        chk("q1_instr", instr_d, 32'hE000_0200);
        tick(); #1;
        chk("q2_req", {31'd0, req}, 32'd0);
        chk("q2_valid", {31'd0, valid_d}, 32'd0);
        tick(); #1;
        chk("q3_req", {31'd0, req}, 32'd0);
        chk("q3_addr", addr, 32'h204);
        tick(); rst_n = 1'b0; pcwr = 1'b0; #1;
        chk("r_addr", addr, 32'h0);
        chk("r_req", {31'd0, req}, 32'd0);
        chk("r_pc8", pc8_d, 32'h8);
        tick(); rst_n = 1'b1; #1;
        chk("r2_req", {31'd0, req}, 32'd1);
        tick(); #1;
        chk("r3_instr", instr_d, 32'hE000_0000);
        chk("r3_addr", addr, 32'h4);

        // FlushD bubbles the arriving instruction
        tick(); flush_d = 1'b1; #1;
        tick(); flush_d = 1'b0; #1;
        chk("f1_valid", {31'd0, valid_d}, 32'd0);
        chk("f1_instr", instr_d, Nop);
        chk("f1_addr", addr, 32'hC);
        tick(); #1;
        chk("f2_instr", instr_d, 32'hE000_000C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
